// File: rtl/liteeth_sram_pkg.sv
// liteeth_sram_pkg: shared types, limits and helpers for the configurable LiteEth SRAM
package liteeth_sram_pkg;
  localparam int MAX_READ_LATENCY = 2;
  localparam int MAX_BITS = 512;
  localparam int MAX_WMASK = MAX_BITS / 8;
  typedef enum logic {ST_CLEAR, ST_READY} sram_state_e;
  function automatic logic [MAX_BITS-1:0] expand_wmask(input logic [MAX_WMASK-1:0] mask);
    logic [MAX_BITS-1:0] m;
    for (int b = 0; b < MAX_WMASK; b++) m[b*8 +: 8] = {8{mask[b]}};
    return m;
  endfunction
endpackage

// File: rtl/liteeth_sram_out_pipe.sv
// liteeth_sram_out_pipe: read data/valid output stage with hold-on-idle and flush-on-reset
module liteeth_sram_out_pipe
  import liteeth_sram_pkg::*;
#(
  parameter int BITS = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic [BITS-1:0] data,
  output logic [BITS-1:0] rd,
  output logic            rd_valid
);
  logic [BITS-1:0] s_data;
  logic            s_valid;
  generate
    if (READ_LATENCY == MAX_READ_LATENCY) begin : g_two
      // extra register stage for the two-cycle latency option
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s_data  <= '0;
          s_valid <= 1'b0;
        end else begin
          s_valid <= req;
          if (req) s_data <= data;
        end
      end
    end else begin : g_one
      assign s_data  = data;
      assign s_valid = req;
    end
  endgenerate
  // output register: load only on a valid beat so idle cycles keep the last data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd       <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= s_valid;
      if (s_valid) rd <= s_data;
    end
  end
endmodule

// File: rtl/liteeth_1rw1r_sram_cfg.sv
// liteeth_1rw1r_sram_cfg: configurable 1RW+1R SRAM with byte masks, bypass, clear-on-reset and range checking
module liteeth_1rw1r_sram_cfg
  import liteeth_sram_pkg::*;
#(
  parameter int BITS           = 32,
  parameter int WORD_DEPTH     = 384,
  parameter int ADDR_WIDTH     = $clog2(WORD_DEPTH),
  parameter int WMASK_WIDTH    = BITS / 8,
  parameter int READ_LATENCY   = 1,
  parameter int RW_BYPASS      = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   init_done_out,
  input  logic                   rw0_ce_in,
  input  logic                   rw0_we_in,
  input  logic [WMASK_WIDTH-1:0] rw0_wmask_in,
  input  logic [ADDR_WIDTH-1:0]  rw0_addr_in,
  input  logic [BITS-1:0]        rw0_wd_in,
  output logic [BITS-1:0]        rw0_rd_out,
  output logic                   rw0_rd_valid_out,
  input  logic                   r0_ce_in,
  input  logic [ADDR_WIDTH-1:0]  r0_addr_in,
  output logic [BITS-1:0]        r0_rd_out,
  output logic                   r0_rd_valid_out,
  output logic                   addr_err_out
);
  logic [BITS-1:0]       mem [WORD_DEPTH];
  sram_state_e           state, state_n;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  ready, clr_last, rw0_ok, r0_ok, rw0_wr, hit;
  logic [BITS-1:0]       bm, rw0_old, r0_old, merged, r0_data;
  assign ready    = state == ST_READY;
  assign clr_last = clr_cnt == ADDR_WIDTH'(WORD_DEPTH - 1);
  assign rw0_ok   = 32'(rw0_addr_in) < WORD_DEPTH;
  assign r0_ok    = 32'(r0_addr_in) < WORD_DEPTH;
  assign bm       = BITS'(expand_wmask(MAX_WMASK'(rw0_wmask_in)));
  assign rw0_old  = rw0_ok ? mem[rw0_addr_in] : '0;
  assign r0_old   = r0_ok ? mem[r0_addr_in] : '0;
  assign merged   = (rw0_old & ~bm) | (rw0_wd_in & bm);
  assign rw0_wr   = rst_n && ready && rw0_ce_in && rw0_we_in && rw0_ok;
  assign hit      = RW_BYPASS != 0 && rw0_wr && r0_addr_in == rw0_addr_in;
  assign r0_data  = hit ? merged : r0_old;
  // leave CLEAR on the edge that writes the last word
  always_comb state_n = (state == ST_CLEAR && clr_last) ? ST_READY : state;
  // state, clear counter, init handshake and sticky address error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= CLEAR_ON_RESET != 0 ? ST_CLEAR : ST_READY;
      clr_cnt   <= '0;
      init_done_out <= 1'b0;
      addr_err_out  <= 1'b0;
    end else begin
      state         <= state_n;
      init_done_out <= state_n == ST_READY;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (ready && ((rw0_ce_in && !rw0_ok) || (r0_ce_in && !r0_ok))) addr_err_out <= 1'b1;
    end
  end
  // single write port shared by the clear sweep and byte-masked rw0 writes
  always_ff @(posedge clk) begin
    if (rst_n && state == ST_CLEAR) mem[clr_cnt] <= '0;
    else if (rw0_wr) mem[rw0_addr_in] <= merged;
  end
  liteeth_sram_out_pipe #(.BITS(BITS), .READ_LATENCY(READ_LATENCY)) u_rw0_pipe (
    .clk(clk), .rst_n(rst_n), .req(ready && rw0_ce_in), .data(rw0_old),
    .rd(rw0_rd_out), .rd_valid(rw0_rd_valid_out)
  );
  liteeth_sram_out_pipe #(.BITS(BITS), .READ_LATENCY(READ_LATENCY)) u_r0_pipe (
    .clk(clk), .rst_n(rst_n), .req(ready && r0_ce_in), .data(r0_data),
    .rd(r0_rd_out), .rd_valid(r0_rd_valid_out)
  );
endmodule

// File: tb/tb_liteeth_1rw1r_sram_cfg.sv
// tb_liteeth_1rw1r_sram_cfg: directed table-driven bench for two SRAM configurations sharing one stimulus
module tb_liteeth_1rw1r_sram_cfg;
  logic clk = 1'b0, rst_n = 1'b0;
  logic rw_ce = 0, rw_we = 0, r_ce = 0;
  logic [3:0] wmask = '0;
  logic [8:0] rw_addr = '0, r_addr = '0;
  logic [31:0] wd = '0;
  logic init1, rw_v1, r_v1, err1, init2, rw_v2, r_v2, err2;
  logic [31:0] rw_rd1, r_rd1, rw_rd2, r_rd2, last2;
  int checks = 0, errors = 0, n;
  always #5 clk = ~clk;

  liteeth_1rw1r_sram_cfg dut (
    .clk(clk), .rst_n(rst_n), .init_done_out(init1),
    .rw0_ce_in(rw_ce), .rw0_we_in(rw_we), .rw0_wmask_in(wmask), .rw0_addr_in(rw_addr),
    .rw0_wd_in(wd), .rw0_rd_out(rw_rd1), .rw0_rd_valid_out(rw_v1),
    .r0_ce_in(r_ce), .r0_addr_in(r_addr), .r0_rd_out(r_rd1), .r0_rd_valid_out(r_v1),
    .addr_err_out(err1)
  );
  liteeth_1rw1r_sram_cfg #(.READ_LATENCY(2), .RW_BYPASS(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .init_done_out(init2),
    .rw0_ce_in(rw_ce), .rw0_we_in(rw_we), .rw0_wmask_in(wmask), .rw0_addr_in(rw_addr),
    .rw0_wd_in(wd), .rw0_rd_out(rw_rd2), .rw0_rd_valid_out(rw_v2),
    .r0_ce_in(r_ce), .r0_addr_in(r_addr), .r0_rd_out(r_rd2), .r0_rd_valid_out(r_v2),
    .addr_err_out(err2)
  );

  typedef struct {
    logic rw_ce; logic rw_we; logic [3:0] mask; logic [8:0] rw_addr; logic [31:0] wd;
    logic r_ce; logic [8:0] r_addr;
    logic e_rwv; logic [31:0] e_rw; logic e_rv; logic [31:0] e_r; logic e_err;
    logic e2v; logic [31:0] e2;
  } vec_t;
  vec_t v [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    rw_ce = 0; rw_we = 0; r_ce = 0;
  endtask

  initial begin
    v[0] = '{1, 1, 4'hF, 9'd5, 32'hDEADBEEF, 1, 9'd5, 1, 32'h0, 1, 32'hDEADBEEF, 0, 1, 32'h0};
    v[1] = '{1, 1, 4'h2, 9'd5, 32'h00001200, 1, 9'd6, 1, 32'hDEADBEEF, 1, 32'h0, 0, 1, 32'h0};
    v[2] = '{0, 0, 4'h0, 9'd0, 32'h0, 1, 9'd5, 0, 32'hDEADBEEF, 1, 32'hDEAD12EF, 0, 1, 32'hDEAD12EF};
    v[3] = '{1, 1, 4'hF, 9'd7, 32'hA5A5A5A5, 1, 9'd7, 1, 32'h0, 1, 32'hA5A5A5A5, 0, 1, 32'h0};
    v[4] = '{1, 0, 4'h0, 9'd7, 32'h0, 0, 9'd0, 1, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0, 0, 32'h0};
    v[5] = '{1, 1, 4'h1, 9'd7, 32'h000000FF, 1, 9'd7, 1, 32'hA5A5A5A5, 1, 32'hA5A5A5FF, 0, 1, 32'hA5A5A5A5};
    v[6] = '{1, 0, 4'h0, 9'd0, 32'h0, 1, 9'd383, 1, 32'h0, 1, 32'h0, 0, 1, 32'h0};
    v[7] = '{1, 1, 4'hF, 9'd400, 32'h12345678, 1, 9'd400, 1, 32'h0, 1, 32'h0, 1, 1, 32'h0};
    v[8] = '{1, 0, 4'h0, 9'd7, 32'h0, 1, 9'd5, 1, 32'hA5A5A5FF, 1, 32'hDEAD12EF, 1, 1, 32'hDEAD12EF};
    v[9] = '{0, 0, 4'h0, 9'd0, 32'h0, 0, 9'd0, 0, 32'hA5A5A5FF, 0, 32'hDEAD12EF, 1, 0, 32'h0};

    step(); step();
    chk("reset_outs1", {rw_rd1, r_rd1}, 64'h0);
    chk("reset_flags1", {init1, rw_v1, r_v1, err1}, 64'h0);
    chk("reset_outs2", {rw_rd2, r_rd2}, 64'h0);
    chk("reset_flags2", {init2, rw_v2, r_v2, err2}, 64'h0);

    rst_n = 1;
    n = 0;
    while (!init1 && n < 1000) begin step(); n++; end
    chk("init_edges", 64'(n), 64'd384);
    chk("init2", {63'h0, init2}, 64'h1);

    for (int a = 0; a < 384; a++) begin
      r_ce = 1; r_addr = 9'(a);
      step();
      chk("clear_read", {r_v1, r_rd1}, {1'b1, 32'h0});
    end
    idle(); step(); step();
    last2 = 32'h0;

    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        rw_ce = v[i].rw_ce; rw_we = v[i].rw_we; wmask = v[i].mask; rw_addr = v[i].rw_addr;
        wd = v[i].wd; r_ce = v[i].r_ce; r_addr = v[i].r_addr;
      end else idle();
      step();
      if (i < 10) begin
        chk($sformatf("vec%0d_rw", i), {rw_v1, rw_rd1}, {v[i].e_rwv, v[i].e_rw});
        chk($sformatf("vec%0d_r", i), {r_v1, r_rd1}, {v[i].e_rv, v[i].e_r});
        chk($sformatf("vec%0d_err", i), {63'h0, err1}, {63'h0, v[i].e_err});
      end
      if (i > 0 && v[i-1].e2v) last2 = v[i-1].e2;
      chk($sformatf("vec%0d_r_lat2", i), {r_v2, r_rd2}, {(i > 0 && v[i-1].e2v), last2});
    end
    chk("err2_sticky", {63'h0, err2}, 64'h1);

    for (int k = 1; k <= 3; k++) begin
      rw_ce = 1; rw_we = 1; wmask = 4'hF; rw_addr = 9'(k); wd = 32'h11111111 * k;
      step();
    end
    idle(); step(); step();
    for (int k = 0; k < 6; k++) begin
      r_ce = k < 3; r_addr = 9'(k + 1);
      step();
      if (k < 3) chk($sformatf("burst_lat1_%0d", k), {r_v1, r_rd1}, {1'b1, 32'h11111111 * (k + 1)});
      if (k >= 1 && k <= 3) chk($sformatf("burst_lat2_%0d", k), {r_v2, r_rd2}, {1'b1, 32'h11111111 * k});
      else chk($sformatf("burst_lat2_idle%0d", k), {63'h0, r_v2}, 64'h0);
    end

    idle(); rst_n = 0;
    step();
    chk("rereset", {init1, err1, rw_v1, r_v1, rw_rd1, r_rd1}, 64'h0);
    rst_n = 1;
    repeat (100) step();
    chk("mid_clear_init", {63'h0, init1}, 64'h0);
    rst_n = 0;
    step();
    rst_n = 1;
    rw_ce = 1; rw_we = 1; wmask = 4'hF; rw_addr = 9'd5; wd = 32'hFFFFFFFF; r_ce = 1; r_addr = 9'd400;
    n = 0;
    while (!init1 && n < 1000) begin
      step(); n++;
      chk("clear_quiet", {59'h0, rw_v1, r_v1, err1, rw_v2, r_v2}, 64'h0);
    end
    idle();
    chk("restart_edges", 64'(n), 64'd384);
    r_ce = 1; r_addr = 9'd5;
    step();
    chk("post_clear_read", {r_v1, r_rd1}, {1'b1, 32'h0});
    chk("post_clear_err", {63'h0, err1}, 64'h0);
    idle(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
